// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator.
package product_acc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int PROD_W   = 6;
  localparam int CNT_W    = 8;
  localparam int PROD_MAX = 49;
endpackage

// File: rtl/product_accumulator_if.sv
// Product input channel, block-sum output channel and restart control.
interface product_accumulator_if #(
  parameter int ACC_W = 8
);
  import product_acc_pkg::*;

  logic              clear;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_count;
  logic              overflow;

  modport master (
    output clear, prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid, acc_out, acc_count, overflow
  );

  modport slave (
    input  clear, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc_out, acc_count, overflow
  );
endinterface

// File: rtl/product_acc_adder.sv
// ACC_W+1 bit add with carry-out; saturates when PRODUCT_ACC_SATURATE_EN is defined, wraps otherwise.
module product_acc_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = full[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Products are non-negative, so once pinned at max every later add keeps it there.
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Accumulates BLOCK_LEN products per block and presents each block sum on a valid/ready channel.
// Optional saturation via PRODUCT_ACC_SATURATE_EN (wraps when undefined).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);
  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             valid_q;
  logic             accept;

  // Ready is the only combinational output so clear can veto a same-cycle accept.
  assign bus.prod_ready = (state == ACCUM) && !bus.clear;
  assign accept         = bus.prod_valid && bus.prod_ready;

  product_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc   (acc),
    .prod  (bus.prod),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.clear) begin
      state   <= ACCUM;
      acc     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (accept) begin
            acc   <= sum;
            count <= count + 1'b1;
            ovf   <= ovf | carry;
            if (count == CNT_W'(BLOCK_LEN - 1)) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state   <= ACCUM;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.acc_valid = valid_q;
  assign bus.acc_out   = acc;
  assign bus.acc_count = count;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed checks of product_accumulator against a sum-based reference model.
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam int ACC_W = 8;
  localparam int unsigned MAXV = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(ACC_W)) b4 ();
  product_accumulator_if #(.ACC_W(ACC_W)) b8 ();

  product_accumulator #(.ACC_W(ACC_W), .BLOCK_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  product_accumulator #(.ACC_W(ACC_W), .BLOCK_LEN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: block result from the true arithmetic sum of its products.
  function automatic int unsigned exp_acc(input int unsigned s);
`ifdef PRODUCT_ACC_SATURATE_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  function automatic logic [31:0] exp_ovf(input int unsigned s);
    return (s > MAXV) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product to dut4 and wait for the handshake (bounded).
  task automatic send4(input logic [5:0] p);
    logic rdy;
    bit   done;
    done = 0;
    b4.prod_valid = 1'b1;
    b4.prod       = p;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      rdy = b4.prod_ready;
      tick();
      if (rdy) done = 1;
    end
    b4.prod_valid = 1'b0;
    chk("send_handshake", 32'(done), 32'd1);
  endtask

  // Check a held block result on dut4, then release it with acc_ready.
  task automatic finish4(input string tag, input int unsigned s);
    chk({tag, "_valid"}, 32'(b4.acc_valid), 32'd1);
    chk({tag, "_acc"}, 32'(b4.acc_out), exp_acc(s));
    chk({tag, "_ovf"}, 32'(b4.overflow), exp_ovf(s));
    chk({tag, "_cnt"}, 32'(b4.acc_count), 32'd4);
    b4.acc_ready = 1'b1;
    tick();
    b4.acc_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(b4.acc_valid), 32'd0);
    chk({tag, "_rel_acc"}, 32'(b4.acc_out), 32'd0);
    chk({tag, "_rel_cnt"}, 32'(b4.acc_count), 32'd0);
  endtask

  initial begin
    int unsigned s;
    logic [5:0] vals[4];
    logic [5:0] p;

    rst_n = 1'b0;
    b4.clear = 0; b4.prod_valid = 1; b4.prod = 6'd7; b4.acc_ready = 0;
    b8.clear = 0; b8.prod_valid = 0; b8.prod = 6'd0; b8.acc_ready = 0;

    // Reset held three cycles with a product offered
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(b4.prod_ready), 32'd0);
      chk("rst_valid", 32'(b4.acc_valid), 32'd0);
      chk("rst_acc", 32'(b4.acc_out), 32'd0);
      chk("rst_cnt", 32'(b4.acc_count), 32'd0);
      chk("rst_ovf", 32'(b4.overflow), 32'd0);
    end
    rst_n = 1'b1;
    #1 chk("idle_ready", 32'(b4.prod_ready), 32'd0);
    tick();
    chk("post_rst_ready", 32'(b4.prod_ready), 32'd1);
    chk("post_rst_cnt", 32'(b4.acc_count), 32'd0);
    b4.prod_valid = 1'b0;

    // Basic block 9,12,49,0 back-to-back
    vals = '{6'd9, 6'd12, 6'd49, 6'd0};
    s = 0;
    for (int i = 0; i < 4; i++) begin
      send4(vals[i]);
      s += vals[i];
      chk("basic_cnt", 32'(b4.acc_count), 32'(i + 1));
      chk("basic_run", 32'(b4.acc_out), s);
      if (i < 3) chk("basic_no_valid", 32'(b4.acc_valid), 32'd0);
    end
    chk("basic_sum", 32'(b4.acc_out), 32'd70);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_acc", 32'(b4.acc_out), 32'd70);
      chk("hold_ready", 32'(b4.prod_ready), 32'd0);
    end
    finish4("basic", 70);
    chk("basic_ready_again", 32'(b4.prod_ready), 32'd1);

    // Overflow on the 8-product instance
    b8.prod_valid = 1'b1;
    b8.prod       = 6'd49;
    repeat (8) tick();
    b8.prod_valid = 1'b0;
    chk("ovf_valid", 32'(b8.acc_valid), 32'd1);
    chk("ovf_cnt", 32'(b8.acc_count), 32'd8);
    chk("ovf_acc", 32'(b8.acc_out), exp_acc(392));
    chk("ovf_flag", 32'(b8.overflow), 32'd1);
    tick();
    chk("ovf_hold", 32'(b8.overflow), 32'd1);
    b8.acc_ready = 1'b1;
    tick();
    b8.acc_ready = 1'b0;
    chk("ovf_cleared", 32'(b8.overflow), 32'd0);
    chk("ovf_acc_cleared", 32'(b8.acc_out), 32'd0);

    // Clear mid-block with a product offered
    send4(6'd20);
    send4(6'd30);
    chk("pre_clear_acc", 32'(b4.acc_out), 32'd50);
    b4.clear = 1'b1; b4.prod_valid = 1'b1; b4.prod = 6'd5;
    #1 chk("clear_ready", 32'(b4.prod_ready), 32'd0);
    tick();
    b4.clear = 1'b0; b4.prod_valid = 1'b0;
    chk("clear_acc", 32'(b4.acc_out), 32'd0);
    chk("clear_cnt", 32'(b4.acc_count), 32'd0);
    s = 0;
    for (int i = 0; i < 4; i++) begin
      p = 6'($urandom_range(0, PROD_MAX));
      send4(p);
      s += p;
    end
    finish4("fresh", s);

    // Random producer stalls and consumer back-pressure, 100 blocks
    begin
      logic [5:0] q[$];
      logic [5:0] cur;
      bit pend, acc_now;
      int blocks;
      int unsigned bs;
      pend = 0; blocks = 0; cur = 0;
      for (int cyc = 0; cyc < 5000 && blocks < 100; cyc++) begin
        if (!pend) begin
          cur  = 6'($urandom_range(0, PROD_MAX));
          pend = ($urandom_range(0, 2) != 0);
        end
        b4.prod_valid = pend;
        b4.prod       = cur;
        b4.acc_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc_now = b4.prod_valid && b4.prod_ready;
        if (acc_now) q.push_back(cur);
        if (b4.acc_valid && b4.acc_ready) begin
          chk("rnd_qsize", 32'(q.size()), 32'd4);
          if (q.size() >= 4) begin
            bs = 0;
            for (int k = 0; k < 4; k++) bs += q.pop_front();
            chk("rnd_acc", 32'(b4.acc_out), exp_acc(bs));
            chk("rnd_ovf", 32'(b4.overflow), exp_ovf(bs));
            chk("rnd_cnt", 32'(b4.acc_count), 32'd4);
          end
          blocks++;
        end
        tick();
        if (acc_now) pend = 0;
      end
      b4.prod_valid = 1'b0;
      b4.acc_ready  = 1'b0;
      chk("rnd_blocks", 32'(blocks), 32'd100);
    end

    // Reset while holding a result; drain any partial block first
    b4.clear = 1'b1;
    tick();
    b4.clear = 1'b0;
    for (int i = 0; i < 4; i++) send4(6'd10);
    chk("rsthold_valid_pre", 32'(b4.acc_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rsthold_valid", 32'(b4.acc_valid), 32'd0);
    chk("rsthold_acc", 32'(b4.acc_out), 32'd0);
    chk("rsthold_cnt", 32'(b4.acc_count), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
